com_csr_arb: RTL and testbench
==============================

Name: com_csr_arb

Overview:
- Round-robin arbiter that merges NM CSR masters in the clk_s domain onto one CSR master port.
- The merged port feeds the source-side (slave) CSR interface of the clock-domain-crossing stage directly downstream.
- A granted transaction is held until its handshake completes, so the downstream read tracking is never disturbed mid-transaction.
- Each master uses the standard CSR valid/ready/write/addr/wdata/wstrb/rdata protocol.

Parameters:
- NM, 2, number of upstream masters (2..8).
- AW, 16, address width.
- DW, 32, data width.
- SW, DW/8, write-strobe width.
- TO_CYC, 1024, timeout cycle count; used only with the optional feature.

Ports:
- clk_s  in  1  clock.
- rst_n_s  in  1  reset, asynchronous, active-low.
- clear_s  in  1  synchronous clear, same effect as reset.
- s_csr_valid  in  NM  per-master request valid.
- s_csr_write  in  NM  per-master 1=write, 0=read.
- s_csr_addr  in  NM*AW  per-master address, master i in bits [i*AW +: AW].
- s_csr_wdata  in  NM*DW  per-master write data.
- s_csr_wstrb  in  NM*SW  per-master write strobes.
- s_csr_ready  out  NM  per-master completion.
- s_csr_rdata  out  DW  read data, shared, valid with s_csr_ready[i] on a read.
- m_csr_valid / m_csr_write / m_csr_addr / m_csr_wdata / m_csr_wstrb  out  1/1/AW/DW/SW  downstream request.
- m_csr_ready  in  1  downstream completion.
- m_csr_rdata  in  DW  downstream read data.
- busy  out  1  a transaction is granted.
- txn_cnt  out  16  completed-transaction counter, wraps.

Behaviour:
- Master rules: once s_csr_valid[i] rises, master i holds it and its payload stable until s_csr_ready[i]=1. Violating this is a protocol error and is not checked.
- FSM ARB: ptr holds the last served index.
  - Winner is the first requesting index searched from ptr+1 upward, modulo NM.
  - On any request: register gnt=winner and go to GNT next cycle (1-cycle arbitration latency).
  - No request: stay in ARB.
- FSM GNT:
  - m_csr_* = payload of master gnt, m_csr_valid = s_csr_valid[gnt].
  - s_csr_ready[gnt] = m_csr_ready; all other s_csr_ready bits = 0.
  - s_csr_rdata = m_csr_rdata.
  - On m_csr_valid && m_csr_ready: ptr<=gnt, txn_cnt++, next state ARB.
- m_csr_valid=0 in ARB. The arbiter inserts at least 1 idle cycle between transactions, so back-to-back throughput is one transaction per (downstream latency + 1) cycles.
- Reset / clear_s values:
  - state=ARB, gnt=0, ptr=NM-1 (so master 0 wins first), txn_cnt=0.
  - busy=0, m_csr_valid=0, s_csr_ready=0, m_csr_* payload=0.
  - s_csr_rdata=m_csr_rdata (passthrough).
- Clear mid-GNT drops the transaction. clear_s must be asserted together with the downstream clear.
- Simultaneous requests from all masters: strict rotation, each served once per NM grants.
- A new request arriving during GNT waits; it cannot preempt.
- Combinational paths: only ready/rdata are passthrough. Payload and valid are muxed from registered gnt.
- busy = (state==GNT).

Optional Feature:
- Macro: COM_CSR_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in GNT and resets on entry to GNT.
  - If it reaches TO_CYC-1 without m_csr_ready: force s_csr_ready[gnt]=1 for one cycle, s_csr_rdata={DW/16{16'hDEAD}}, and return to ARB.
  - Extra output to_err (1 bit) is set on a timeout, sticky until clear_s or reset.
  - m_csr_valid drops in the same cycle.
- Without the macro: no counter, no to_err port, and GNT waits indefinitely.

Decomposition:
- Package com_csr_pkg: FSM state enum (ARB, GNT), timeout pattern constant, clog2-based index width localparam helper.
- One sub-module, com_rr_pick: combinational round-robin winner selection from req[NM] and ptr, producing a one-hot output plus an index output.

Test Plan:
- Single write: master0 write addr 0x0010 data 0x12345678 strb 0xF, downstream ready 3 cycles after m_csr_valid -> m_csr_addr=0x0010, s_csr_ready[0] pulses once, txn_cnt=1.
- Read: master1 read addr 0x0020, downstream returns 0xA5A5A5A5 with ready -> s_csr_ready[1]=1 with s_csr_rdata=0xA5A5A5A5, s_csr_ready[0] stays 0.
- Contention: NM=2, both masters request continuously for 6 transactions -> grant order 0,1,0,1,0,1, with at least 1 idle cycle between m_csr_valid pulses.
- Late request: master0 granted, master1 asserts mid-transaction -> master1 served immediately after, with no preemption.
- Reset mid-GNT: assert rst_n_s=0 while m_csr_valid=1 -> all outputs go to 0 asynchronously, next grant goes to master0.
- Timeout (macro on, TO_CYC=16): read with downstream never ready -> s_csr_ready pulses at the 16th GNT cycle with rdata 0xDEADDEAD, to_err=1 until clear_s.

Source files
------------

// File: rtl/com_csr_pkg.sv
// Shared types and constants for the CSR round-robin arbiter.
package com_csr_pkg;

  // Arbiter FSM: ST_ARB picks a winner, ST_GNT holds it until the handshake completes.
  typedef enum logic {
    ST_ARB = 1'b0,
    ST_GNT = 1'b1
  } arb_state_e;

  // Read data returned to a master whose transaction timed out.
  localparam logic [15:0] TO_PATTERN = 16'hDEAD;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/com_rr_pick.sv
// Combinational round-robin winner selection: first requester after ptr, modulo NM.
module com_rr_pick #(
  parameter int NM = 2,
  parameter int IW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NM-1:0] gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  // Scan ptr+1, ptr+2, ... wrapping at NM; the first set request wins.
  always_comb begin
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    j       = 0;
    for (int k = 1; k <= NM; k++) begin
      j = (int'(ptr) + k) % NM;
      if (!any_req && req[j]) begin
        any_req    = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/com_csr_arb.sv
// Round-robin arbiter merging NM CSR masters onto one downstream CSR port.
// A grant is held until its handshake completes; one idle cycle separates grants.
// Optional feature: define COM_CSR_ARB_TIMEOUT_EN to add a grant timeout and
// the sticky to_err output.
module com_csr_arb
  import com_csr_pkg::*;
#(
  parameter int NM     = 2,
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int SW     = DW / 8,
  parameter int TO_CYC = 1024
) (
  input  logic             clk_s,
  input  logic             rst_n_s,
  input  logic             clear_s,
  input  logic [NM-1:0]    s_csr_valid,
  input  logic [NM-1:0]    s_csr_write,
  input  logic [NM*AW-1:0] s_csr_addr,
  input  logic [NM*DW-1:0] s_csr_wdata,
  input  logic [NM*SW-1:0] s_csr_wstrb,
  output logic [NM-1:0]    s_csr_ready,
  output logic [DW-1:0]    s_csr_rdata,
  output logic             m_csr_valid,
  output logic             m_csr_write,
  output logic [AW-1:0]    m_csr_addr,
  output logic [DW-1:0]    m_csr_wdata,
  output logic [SW-1:0]    m_csr_wstrb,
  input  logic             m_csr_ready,
  input  logic [DW-1:0]    m_csr_rdata,
  output logic             busy,
  output logic [15:0]      txn_cnt
`ifdef COM_CSR_ARB_TIMEOUT_EN
  ,
  output logic             to_err
`endif
);

  localparam int IW = idx_w(NM);

  arb_state_e    state;
  logic [IW-1:0] gnt;
  logic [NM-1:0] gnt_oh;
  logic [IW-1:0] ptr;

  logic [NM-1:0] pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  logic          done;
  logic          to_hit;

  com_rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .req     (s_csr_valid),
    .ptr     (ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  assign busy = (state == ST_GNT);
  assign done = m_csr_valid && m_csr_ready;

`ifdef COM_CSR_ARB_TIMEOUT_EN
  localparam int TCW = idx_w(TO_CYC);
  logic [TCW-1:0] to_cnt;

  // A grant that reaches its last allowed cycle without downstream ready is abandoned.
  assign to_hit = busy && (to_cnt == TCW'(TO_CYC - 1)) && !m_csr_ready;

  // Grant-age counter (zero on entry to GNT) and sticky timeout flag.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (clear_s) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (busy) to_cnt <= to_cnt + 1'b1;
      else      to_cnt <= '0;
      if (to_hit) to_err <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Arbitration FSM: register the winner in ARB, release it after handshake or timeout.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state   <= ST_ARB;
      gnt     <= '0;
      gnt_oh  <= '0;
      ptr     <= IW'(NM - 1);
      txn_cnt <= '0;
    end else if (clear_s) begin
      state   <= ST_ARB;
      gnt     <= '0;
      gnt_oh  <= '0;
      ptr     <= IW'(NM - 1);
      txn_cnt <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (pick_any) begin
            gnt    <= pick_idx;
            gnt_oh <= pick_oh;
            state  <= ST_GNT;
          end
        end
        ST_GNT: begin
          if (done) begin
            ptr     <= gnt;
            txn_cnt <= txn_cnt + 16'd1;
            state   <= ST_ARB;
          end else if (to_hit) begin
            ptr   <= gnt;
            state <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  // Downstream request muxed from the registered grant; zero outside GNT.
  always_comb begin
    m_csr_valid = 1'b0;
    m_csr_write = 1'b0;
    m_csr_addr  = '0;
    m_csr_wdata = '0;
    m_csr_wstrb = '0;
    if (busy) begin
      m_csr_valid = s_csr_valid[gnt] && !to_hit;
      m_csr_write = s_csr_write[gnt];
      m_csr_addr  = s_csr_addr[gnt*AW +: AW];
      m_csr_wdata = s_csr_wdata[gnt*DW +: DW];
      m_csr_wstrb = s_csr_wstrb[gnt*SW +: SW];
    end
  end

  // Completion and read data pass straight back to the granted master only.
  always_comb begin
    s_csr_ready = '0;
    s_csr_rdata = m_csr_rdata;
    if (busy) s_csr_ready = gnt_oh & {NM{m_csr_ready || to_hit}};
    if (to_hit) s_csr_rdata = {(DW/16){TO_PATTERN}};
  end

endmodule

// File: tb/tb_com_csr_arb.sv
// Self-checking bench for com_csr_arb: directed table, hand-written corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_com_csr_arb;

  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
`ifdef COM_CSR_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic             clk_s = 1'b0;
  logic             rst_n_s = 1'b0;
  logic             clear_s = 1'b0;
  logic [NM-1:0]    s_csr_valid = '0;
  logic [NM-1:0]    s_csr_write = '0;
  logic [NM*AW-1:0] s_csr_addr = '0;
  logic [NM*DW-1:0] s_csr_wdata = '0;
  logic [NM*SW-1:0] s_csr_wstrb = '0;
  logic [NM-1:0]    s_csr_ready;
  logic [DW-1:0]    s_csr_rdata;
  logic             m_csr_valid;
  logic             m_csr_write;
  logic [AW-1:0]    m_csr_addr;
  logic [DW-1:0]    m_csr_wdata;
  logic [SW-1:0]    m_csr_wstrb;
  logic             m_csr_ready = 1'b0;
  logic [DW-1:0]    m_csr_rdata = '0;
  logic             busy;
  logic [15:0]      txn_cnt;
`ifdef COM_CSR_ARB_TIMEOUT_EN
  logic             to_err;
`endif

  com_csr_arb #(
    .NM (NM), .AW (AW), .DW (DW), .SW (SW), .TO_CYC (TO_CYC)
  ) dut (
    .clk_s       (clk_s),
    .rst_n_s     (rst_n_s),
    .clear_s     (clear_s),
    .s_csr_valid (s_csr_valid),
    .s_csr_write (s_csr_write),
    .s_csr_addr  (s_csr_addr),
    .s_csr_wdata (s_csr_wdata),
    .s_csr_wstrb (s_csr_wstrb),
    .s_csr_ready (s_csr_ready),
    .s_csr_rdata (s_csr_rdata),
    .m_csr_valid (m_csr_valid),
    .m_csr_write (m_csr_write),
    .m_csr_addr  (m_csr_addr),
    .m_csr_wdata (m_csr_wdata),
    .m_csr_wstrb (m_csr_wstrb),
    .m_csr_ready (m_csr_ready),
    .m_csr_rdata (m_csr_rdata),
    .busy        (busy),
    .txn_cnt     (txn_cnt)
`ifdef COM_CSR_ARB_TIMEOUT_EN
    ,
    .to_err      (to_err)
`endif
  );

  always #5 clk_s = ~clk_s;

  int n_pass = 0;
  int n_tot  = 0;
  int exp_txn = 0;
  int last_srv = NM - 1;

  typedef struct {
    int          m;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          lat;
    logic [31:0] rdata;
    logic [NM-1:0] exp_rdy;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic set_req(input int m, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] st);
    s_csr_valid[m]           = 1'b1;
    s_csr_write[m]           = wr;
    s_csr_addr[m*AW +: AW]   = a;
    s_csr_wdata[m*DW +: DW]  = d;
    s_csr_wstrb[m*SW +: SW]  = st;
  endtask

  // Waits (bounded) for the downstream request; reports cycles waited.
  task automatic wait_valid(output int w);
    w = 0;
    while (!m_csr_valid && w < 50) begin
      tick();
      #1;
      w++;
    end
    if (w >= 50) chk("grant_wait_expired", 64'(w), 64'(0));
  endtask

  // Round-robin rule: first requester after 'last', wrapping at NM.
  function automatic int next_of(input logic [NM-1:0] mask, input int last);
    for (int k = 1; k <= NM; k++) begin
      if (mask[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  // All masters in mask request continuously; n grants must follow the rotation.
  task automatic serve_loop(input logic [NM-1:0] mask, input int n);
    int w;
    int e;
    for (int i = 0; i < NM; i++)
      if (mask[i]) set_req(i, 1'b1, 16'(16'h0100 + i), 32'hC0DE0000 + i, 4'hF);
    #1;
    for (int t = 0; t < n; t++) begin
      wait_valid(w);
      e = next_of(mask, last_srv);
      chk("rr_order_addr", 64'(m_csr_addr), 64'(16'h0100 + e));
      m_csr_ready = 1'b1;
      #1;
      chk("rr_ready_onehot", 64'(s_csr_ready), 64'(1 << e));
      tick();
      m_csr_ready = 1'b0;
      #1;
      chk("rr_idle_gap", 64'(m_csr_valid), 64'(0));
      exp_txn++;
      last_srv = e;
      chk("rr_txn_cnt", 64'(txn_cnt), 64'(exp_txn));
    end
    s_csr_valid = s_csr_valid & ~mask;
  endtask

  initial begin
    int w;
    bit mb;
    int mcur, mlast, mcnt, stall;
    logic hs;
    logic [NM-1:0] exp_r;

    tbl[0] = '{0, 1'b1, 16'h0010, 32'h12345678, 4'hF, 3, 32'h00000000, 3'b001, 1};
    tbl[1] = '{1, 1'b0, 16'h0020, 32'h00000000, 4'h0, 0, 32'hA5A5A5A5, 3'b010, 2};
    tbl[2] = '{2, 1'b1, 16'hBEEF, 32'hCAFEF00D, 4'h5, 1, 32'h00000000, 3'b100, 3};
    tbl[3] = '{0, 1'b0, 16'h1234, 32'h0, 4'h0, 2, 32'h0BADF00D, 3'b001, 4};
    tbl[4] = '{2, 1'b0, 16'hFFFF, 32'h0, 4'h0, 0, 32'hFFFFFFFF, 3'b100, 5};

    // Reset state, with downstream ready driven high to prove it is gated.
    m_csr_ready = 1'b1;
    m_csr_rdata = 32'h5A5A0001;
    s_csr_valid = 3'b111;
    repeat (2) @(posedge clk_s);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_m_valid", 64'(m_csr_valid), 64'(0));
    chk("rst_s_ready", 64'(s_csr_ready), 64'(0));
    chk("rst_m_addr", 64'(m_csr_addr), 64'(0));
    chk("rst_txn_cnt", 64'(txn_cnt), 64'(0));
    chk("rst_rdata_pass", 64'(s_csr_rdata), 64'(32'h5A5A0001));
`ifdef COM_CSR_ARB_TIMEOUT_EN
    chk("rst_to_err", 64'(to_err), 64'(0));
`endif
    s_csr_valid = '0;
    m_csr_ready = 1'b0;
    rst_n_s     = 1'b1;
    tick();

    // Directed single-master transactions from the table.
    for (int v = 0; v < 5; v++) begin
      set_req(tbl[v].m, tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].strb);
      #1;
      chk("tbl_idle_before", 64'(m_csr_valid), 64'(0));
      wait_valid(w);
      chk("tbl_arb_latency", 64'(w), 64'(1));
      chk("tbl_m_addr", 64'(m_csr_addr), 64'(tbl[v].addr));
      chk("tbl_m_write", 64'(m_csr_write), 64'(tbl[v].wr));
      chk("tbl_m_wdata", 64'(m_csr_wdata), 64'(tbl[v].wdata));
      chk("tbl_m_wstrb", 64'(m_csr_wstrb), 64'(tbl[v].strb));
      for (int c = 0; c < tbl[v].lat; c++) begin
        tick();
        #1;
        chk("tbl_wait_no_ready", 64'(s_csr_ready), 64'(0));
        chk("tbl_wait_valid", 64'(m_csr_valid), 64'(1));
      end
      m_csr_ready = 1'b1;
      m_csr_rdata = tbl[v].rdata;
      #1;
      chk("tbl_s_ready", 64'(s_csr_ready), 64'(tbl[v].exp_rdy));
      chk("tbl_s_rdata", 64'(s_csr_rdata), 64'(tbl[v].rdata));
      tick();
      m_csr_ready = 1'b0;
      s_csr_valid[tbl[v].m] = 1'b0;
      #1;
      chk("tbl_post_valid", 64'(m_csr_valid), 64'(0));
      chk("tbl_post_busy", 64'(busy), 64'(0));
      chk("tbl_post_ready", 64'(s_csr_ready), 64'(0));
      chk("tbl_txn_cnt", 64'(txn_cnt), 64'(tbl[v].exp_cnt));
      exp_txn  = tbl[v].exp_cnt;
      last_srv = tbl[v].m;
    end

    // Contention between masters 0 and 1: strict alternation.
    serve_loop(3'b011, 6);
    tick();

    // Late request: master 1 arrives mid-grant of master 0 and must wait.
    set_req(0, 1'b1, 16'h0A00, 32'h0000AAAA, 4'hF);
    #1;
    wait_valid(w);
    tick();
    set_req(1, 1'b0, 16'h0B00, 32'h0, 4'h0);
    #1;
    tick();
    #1;
    chk("late_no_preempt", 64'(m_csr_addr), 64'(16'h0A00));
    m_csr_ready = 1'b1;
    #1;
    chk("late_ready_m0", 64'(s_csr_ready), 64'(3'b001));
    tick();
    m_csr_ready = 1'b0;
    s_csr_valid[0] = 1'b0;
    #1;
    chk("late_idle", 64'(m_csr_valid), 64'(0));
    tick();
    #1;
    chk("late_m1_next", 64'(m_csr_addr), 64'(16'h0B00));
    chk("late_m1_valid", 64'(m_csr_valid), 64'(1));
    m_csr_ready = 1'b1;
    #1;
    chk("late_ready_m1", 64'(s_csr_ready), 64'(3'b010));
    tick();
    m_csr_ready = 1'b0;
    s_csr_valid[1] = 1'b0;
    exp_txn += 2;
    #1;
    chk("late_txn_cnt", 64'(txn_cnt), 64'(exp_txn));

    // Asynchronous reset in the middle of a grant.
    set_req(1, 1'b1, 16'h0C00, 32'h11112222, 4'h3);
    #1;
    wait_valid(w);
    m_csr_ready = 1'b1;
    #2;
    rst_n_s = 1'b0;
    #1;
    chk("arst_m_valid", 64'(m_csr_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_s_ready", 64'(s_csr_ready), 64'(0));
    chk("arst_m_addr", 64'(m_csr_addr), 64'(0));
    chk("arst_txn_cnt", 64'(txn_cnt), 64'(0));
    tick();
    rst_n_s = 1'b1;
    m_csr_ready = 1'b0;
    s_csr_valid = '0;
    exp_txn  = 0;
    last_srv = NM - 1;
    tick();

    // All masters at once after reset: master 0 first, then strict rotation.
    serve_loop(3'b111, 6);
    tick();

    // Synchronous clear mid-grant drops the transaction and resets the pointer.
    set_req(2, 1'b0, 16'h0D00, 32'h0, 4'h0);
    #1;
    wait_valid(w);
    clear_s = 1'b1;
    tick();
    #1;
    chk("clr_busy", 64'(busy), 64'(0));
    chk("clr_txn_cnt", 64'(txn_cnt), 64'(0));
    clear_s  = 1'b0;
    exp_txn  = 0;
    last_srv = NM - 1;
    serve_loop(3'b110, 2);
    tick();

`ifdef COM_CSR_ARB_TIMEOUT_EN
    // Timeout: downstream never answers a read.
    m_csr_rdata = 32'h11111111;
    set_req(0, 1'b0, 16'h0E00, 32'h0, 4'h0);
    #1;
    wait_valid(w);
    for (int c = 2; c < TO_CYC; c++) begin
      tick();
      #1;
      chk("to_no_ready_yet", 64'(s_csr_ready), 64'(0));
    end
    chk("to_err_before", 64'(to_err), 64'(0));
    tick();
    #1;
    chk("to_ready_pulse", 64'(s_csr_ready), 64'(3'b001));
    chk("to_rdata", 64'(s_csr_rdata), 64'(32'hDEADDEAD));
    chk("to_m_valid_drop", 64'(m_csr_valid), 64'(0));
    tick();
    s_csr_valid[0] = 1'b0;
    #1;
    chk("to_busy_after", 64'(busy), 64'(0));
    chk("to_err_set", 64'(to_err), 64'(1));
    chk("to_txn_unchanged", 64'(txn_cnt), 64'(exp_txn));
    repeat (3) tick();
    chk("to_err_sticky", 64'(to_err), 64'(1));
    clear_s = 1'b1;
    tick();
    clear_s = 1'b0;
    #1;
    chk("to_err_cleared", 64'(to_err), 64'(0));
`endif

    // Randomized traffic against the transaction-level model.
    clear_s = 1'b1;
    tick();
    clear_s = 1'b0;
    mb = 1'b0; mcur = 0; mlast = NM - 1; mcnt = 0; stall = 0; hs = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hs) begin
        mlast = mcur;
        mb    = 1'b0;
        mcnt  = (mcnt + 1) & 16'hFFFF;
        s_csr_valid[mcur] = 1'b0;
      end else if (!mb && (|s_csr_valid)) begin
        mcur = next_of(s_csr_valid, mlast);
        mb   = 1'b1;
      end
      for (int i = 0; i < NM; i++)
        if (!s_csr_valid[i] && ($urandom % 4 == 0))
          set_req(i, 1'($urandom), 16'($urandom), $urandom, 4'($urandom));
      if (mb) m_csr_ready = (stall >= 6) ? 1'b1 : ($urandom % 3 == 0);
      else    m_csr_ready = 1'($urandom);
      stall = (mb && !m_csr_ready) ? stall + 1 : 0;
      m_csr_rdata = $urandom;
      #1;
      exp_r = (mb && m_csr_ready) ? NM'(1 << mcur) : '0;
      chk("rnd_busy", 64'(busy), 64'(mb));
      chk("rnd_m_valid", 64'(m_csr_valid), 64'(mb));
      chk("rnd_m_addr", 64'(m_csr_addr), mb ? 64'(s_csr_addr[mcur*AW +: AW]) : 64'(0));
      chk("rnd_m_wdata", 64'(m_csr_wdata), mb ? 64'(s_csr_wdata[mcur*DW +: DW]) : 64'(0));
      chk("rnd_s_ready", 64'(s_csr_ready), 64'(exp_r));
      chk("rnd_s_rdata", 64'(s_csr_rdata), 64'(m_csr_rdata));
      chk("rnd_txn_cnt", 64'(txn_cnt), 64'(mcnt));
      hs = mb && m_csr_ready;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
